// File: rtl/rv32i_mc_core.sv
`default_nettype none
// ==========================================================================
// Module   : rv32i_mc_core -- multi-cycle RV32I core, valid/ready imem/dmem.
// Option   : RV_ILLEGAL_HALT_EN halts on illegal instructions.  Rev: 1.0
// ==========================================================================
module rv32i_mc_core #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          NUM_REGS = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ready,
  input  logic [31:0] dmem_rdata,
  output logic        retire,
  output logic        halted
);
  localparam logic [6:0] c_OP_LUI    = 7'b0110111;
  localparam logic [6:0] c_OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] c_OP_JAL    = 7'b1101111;
  localparam logic [6:0] c_OP_JALR   = 7'b1100111;
  localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
  localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
  localparam logic [6:0] c_OP_STORE  = 7'b0100011;
  localparam logic [6:0] c_OP_IMM    = 7'b0010011;
  localparam logic [6:0] c_OP_REG    = 7'b0110011;
  localparam int         c_IDX_W     = $clog2(NUM_REGS);
  localparam logic [5:0] c_NREGS     = 6'(NUM_REGS);

`ifdef RV_ILLEGAL_HALT_EN
  typedef enum logic [1:0] {S_FETCH = 2'd0, S_EXEC = 2'd1, S_MEM = 2'd2, S_HALT = 2'd3} state_t;
`else
  typedef enum logic [1:0] {S_FETCH = 2'd0, S_EXEC = 2'd1, S_MEM = 2'd2} state_t;
`endif

  state_t      r_state;
  logic [31:0] r_pc, r_ir;
  logic [31:0] r_regs [NUM_REGS];
  logic        r_imem_req, r_dmem_req, r_dmem_we, r_retire;
  logic [31:0] r_imem_addr, r_dmem_addr, r_dmem_wdata;
  logic [3:0]  r_dmem_be;

  logic [6:0]  w_opcode, w_f7;
  logic [4:0]  w_rd, w_rs1, w_rs2, w_sh;
  logic [2:0]  w_f3;
  logic [31:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j;
  logic [31:0] w_rs1_val, w_rs2_val, w_alu_b, w_alu, w_ea, w_wdata;
  logic [31:0] w_wb_val, w_next_pc, w_ld_word, w_ld_val;
  logic [3:0]  w_be_base, w_be;
  logic        w_alt, w_cmp, w_take, w_rd_ok;
  logic        w_wb_en, w_is_mem, w_is_store, w_illegal;

  assign w_opcode = r_ir[6:0];
  assign w_rd     = r_ir[11:7];
  assign w_f3     = r_ir[14:12];
  assign w_rs1    = r_ir[19:15];
  assign w_rs2    = r_ir[24:20];
  assign w_f7     = r_ir[31:25];
  assign w_imm_i  = {{20{r_ir[31]}}, r_ir[31:20]};
  assign w_imm_s  = {{20{r_ir[31]}}, r_ir[31:25], r_ir[11:7]};
  assign w_imm_b  = {{19{r_ir[31]}}, r_ir[31], r_ir[7], r_ir[30:25], r_ir[11:8], 1'b0};
  assign w_imm_u  = {r_ir[31:12], 12'd0};
  assign w_imm_j  = {{11{r_ir[31]}}, r_ir[31], r_ir[19:12], r_ir[20], r_ir[30:21], 1'b0};

  // Indices beyond the implemented file (RV32E) read as zero and never write.
  assign w_rs1_val = (w_rs1 != 5'd0 && {1'b0, w_rs1} < c_NREGS) ? r_regs[w_rs1[c_IDX_W-1:0]] : 32'd0;
  assign w_rs2_val = (w_rs2 != 5'd0 && {1'b0, w_rs2} < c_NREGS) ? r_regs[w_rs2[c_IDX_W-1:0]] : 32'd0;
  assign w_rd_ok   = (w_rd != 5'd0) && ({1'b0, w_rd} < c_NREGS);

  assign w_alu_b = (w_opcode == c_OP_REG) ? w_rs2_val : w_imm_i;
  assign w_alt   = (w_opcode == c_OP_REG) ? w_f7[5] : (w_f3 == 3'b101 && w_f7[5]);

  always_comb begin
    case (w_f3)
      3'b000:  w_alu = w_alt ? w_rs1_val - w_alu_b : w_rs1_val + w_alu_b;
      3'b001:  w_alu = w_rs1_val << w_alu_b[4:0];
      3'b010:  w_alu = {31'd0, $signed(w_rs1_val) < $signed(w_alu_b)};
      3'b011:  w_alu = {31'd0, w_rs1_val < w_alu_b};
      3'b100:  w_alu = w_rs1_val ^ w_alu_b;
      3'b101:  w_alu = w_alt ? 32'($signed(w_rs1_val) >>> w_alu_b[4:0]) : w_rs1_val >> w_alu_b[4:0];
      3'b110:  w_alu = w_rs1_val | w_alu_b;
      default: w_alu = w_rs1_val & w_alu_b;
    endcase
  end

  always_comb begin
    case (w_f3[2:1])
      2'b00:   w_cmp = (w_rs1_val == w_rs2_val);
      2'b10:   w_cmp = ($signed(w_rs1_val) < $signed(w_rs2_val));
      default: w_cmp = (w_rs1_val < w_rs2_val);
    endcase
    w_take = w_cmp ^ w_f3[0];
  end

  // Misaligned accesses stay inside one word: lanes shifted past byte 3 are dropped.
  assign w_ea      = w_rs1_val + ((w_opcode == c_OP_STORE) ? w_imm_s : w_imm_i);
  assign w_sh      = {w_ea[1:0], 3'b000};
  assign w_be_base = (w_f3[1:0] == 2'b00) ? 4'b0001 : (w_f3[1:0] == 2'b01) ? 4'b0011 : 4'b1111;
  assign w_be      = w_be_base << w_ea[1:0];
  assign w_wdata   = w_rs2_val << w_sh;
  assign w_ld_word = dmem_rdata >> w_sh;

  always_comb begin
    case (w_f3)
      3'b000:  w_ld_val = {{24{w_ld_word[7]}}, w_ld_word[7:0]};
      3'b001:  w_ld_val = {{16{w_ld_word[15]}}, w_ld_word[15:0]};
      3'b100:  w_ld_val = {24'd0, w_ld_word[7:0]};
      3'b101:  w_ld_val = {16'd0, w_ld_word[15:0]};
      default: w_ld_val = w_ld_word;
    endcase
  end

  always_comb begin
    w_wb_en    = 1'b0;
    w_wb_val   = 32'd0;
    w_next_pc  = r_pc + 32'd4;
    w_is_mem   = 1'b0;
    w_is_store = 1'b0;
    w_illegal  = 1'b0;
    case (w_opcode)
      c_OP_LUI:    begin w_wb_en = 1'b1; w_wb_val = w_imm_u; end
      c_OP_AUIPC:  begin w_wb_en = 1'b1; w_wb_val = r_pc + w_imm_u; end
      c_OP_JAL:    begin w_wb_en = 1'b1; w_wb_val = r_pc + 32'd4; w_next_pc = r_pc + w_imm_j; end
      c_OP_JALR: begin
        w_illegal = (w_f3 != 3'b000);
        w_wb_en   = 1'b1;
        w_wb_val  = r_pc + 32'd4;
        w_next_pc = (w_rs1_val + w_imm_i) & ~32'd1;
      end
      c_OP_BRANCH: begin
        w_illegal = (w_f3[2:1] == 2'b01);
        if (w_take) w_next_pc = r_pc + w_imm_b;
      end
      c_OP_LOAD:   begin w_illegal = (w_f3 == 3'b011) || (w_f3[2:1] == 2'b11); w_is_mem = 1'b1; end
      c_OP_STORE:  begin w_illegal = w_f3[2] || (w_f3[1:0] == 2'b11); w_is_mem = 1'b1; w_is_store = 1'b1; end
      c_OP_IMM: begin
        w_illegal = (w_f3 == 3'b001 && w_f7 != 7'b0000000) ||
                    (w_f3 == 3'b101 && w_f7 != 7'b0000000 && w_f7 != 7'b0100000);
        w_wb_en   = 1'b1;
        w_wb_val  = w_alu;
      end
      c_OP_REG: begin
        w_illegal = !(w_f7 == 7'b0000000 || (w_f7 == 7'b0100000 && (w_f3 == 3'b000 || w_f3 == 3'b101)));
        w_wb_en   = 1'b1;
        w_wb_val  = w_alu;
      end
      default: w_illegal = 1'b1;
    endcase
    if (w_illegal) begin
      w_wb_en    = 1'b0;
      w_is_mem   = 1'b0;
      w_is_store = 1'b0;
      w_next_pc  = r_pc + 32'd4;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_FETCH;
      r_pc         <= RESET_PC;
      r_ir         <= 32'd0;
      r_imem_req   <= 1'b0;
      r_imem_addr  <= 32'd0;
      r_dmem_req   <= 1'b0;
      r_dmem_we    <= 1'b0;
      r_dmem_be    <= 4'd0;
      r_dmem_addr  <= 32'd0;
      r_dmem_wdata <= 32'd0;
      r_retire     <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= 32'd0;
    end else begin
      r_retire <= 1'b0;
      case (r_state)
        S_FETCH: begin
          // First cycle out of reset raises the request; later fetches arrive with it set.
          if (!r_imem_req) begin
            r_imem_req  <= 1'b1;
            r_imem_addr <= r_pc;
          end else if (imem_ready) begin
            r_ir       <= imem_rdata;
            r_imem_req <= 1'b0;
            r_state    <= S_EXEC;
          end
        end
        S_EXEC: begin
`ifdef RV_ILLEGAL_HALT_EN
          if (w_illegal) begin
            r_state <= S_HALT;
          end else
`endif
          if (w_is_mem) begin
            r_dmem_req   <= 1'b1;
            r_dmem_we    <= w_is_store;
            r_dmem_be    <= w_is_store ? w_be : 4'd0;
            r_dmem_addr  <= {w_ea[31:2], 2'b00};
            r_dmem_wdata <= w_is_store ? w_wdata : 32'd0;
            r_state      <= S_MEM;
          end else begin
            if (w_wb_en && w_rd_ok) r_regs[w_rd[c_IDX_W-1:0]] <= w_wb_val;
            r_pc        <= w_next_pc;
            r_imem_req  <= 1'b1;
            r_imem_addr <= w_next_pc;
            r_retire    <= 1'b1;
            r_state     <= S_FETCH;
          end
        end
        S_MEM: begin
          if (dmem_ready) begin
            if (!r_dmem_we && w_rd_ok) r_regs[w_rd[c_IDX_W-1:0]] <= w_ld_val;
            r_pc        <= r_pc + 32'd4;
            r_imem_req  <= 1'b1;
            r_imem_addr <= r_pc + 32'd4;
            r_retire    <= 1'b1;
            r_dmem_req  <= 1'b0;
            r_dmem_we   <= 1'b0;
            r_dmem_be   <= 4'd0;
            r_state     <= S_FETCH;
          end
        end
        default: r_state <= r_state;
      endcase
    end
  end

  assign imem_req   = r_imem_req;
  assign imem_addr  = r_imem_addr;
  assign dmem_req   = r_dmem_req;
  assign dmem_we    = r_dmem_we;
  assign dmem_be    = r_dmem_be;
  assign dmem_addr  = r_dmem_addr;
  assign dmem_wdata = r_dmem_wdata;
  assign retire     = r_retire;
`ifdef RV_ILLEGAL_HALT_EN
  assign halted     = (r_state == S_HALT);
`else
  assign halted     = 1'b0;
`endif
endmodule
`default_nettype wire

// File: tb/tb_rv32i_mc_core.sv
`default_nettype none
// Scoreboard bench for rv32i_mc_core: register results are observed through stores,
// control flow through the fetch address stream.
module tb_rv32i_mc_core;
  localparam logic [6:0] c_LOAD = 7'b0000011;
  localparam logic [6:0] c_IMM  = 7'b0010011;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req, imem_ready, dmem_req, dmem_we, dmem_ready, retire, halted;
  logic [31:0] imem_addr, imem_rdata, dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_be;

  rv32i_mc_core #(.RESET_PC(32'h100), .NUM_REGS(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_be(dmem_be), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
    .retire(retire), .halted(halted)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    int          hold;
  } dexp_t;

  dexp_t       dq[$];
  logic [31:0] fq[$];
  logic [31:0] rom [0:255];
  int          wait_tab [0:31];
  logic [31:0] rdata_tab [0:31];
  int          n_push = 0, acc_n = 0, dcnt = 0, cyc = 0;
  int          n_chk = 0, n_pass = 0, n_fetch = 0, ret_n = 0;
  int          ret_cyc [0:63];

  assign imem_ready = imem_req;
  assign imem_rdata = rom[imem_addr[9:2]];
  assign dmem_ready = dmem_req && (dcnt >= wait_tab[acc_n]);
  assign dmem_rdata = rdata_tab[acc_n];

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) dcnt <= 0;
    else if (dmem_req && dmem_ready) begin
      dcnt  <= 0;
      acc_n <= acc_n + 1;
    end else if (dmem_req) dcnt <= dcnt + 1;
    else dcnt <= 0;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic fail_now(input string name);
    n_chk++;
    $display("FAIL %s: condition not reached", name);
  endtask

  function automatic logic [31:0] enc_i(input logic [31:0] imm, input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd, input logic [6:0] op);
    return {imm[11:0], rs1, f3, rd, op};
  endfunction
  function automatic logic [31:0] enc_s(input logic [31:0] imm, input logic [4:0] rs2, input logic [4:0] rs1,
                                        input logic [2:0] f3);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'b0100011};
  endfunction
  function automatic logic [31:0] enc_b(input logic [31:0] imm, input logic [4:0] rs2, input logic [4:0] rs1,
                                        input logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
  endfunction
  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction

  task automatic put(input logic [31:0] a, input logic [31:0] w);
    rom[a[9:2]] = w;
  endtask

  task automatic exp_st(input logic [31:0] a, input logic [3:0] be, input logic [31:0] d, input int w);
    dexp_t e;
    e.we = 1'b1; e.addr = a; e.be = be; e.wdata = d; e.hold = w + 1;
    dq.push_back(e);
    wait_tab[n_push] = w;
    rdata_tab[n_push] = 32'd0;
    n_push++;
  endtask

  task automatic exp_ld(input logic [31:0] a, input logic [31:0] rd);
    dexp_t e;
    e.we = 1'b0; e.addr = a; e.be = 4'd0; e.wdata = 32'd0; e.hold = 1;
    dq.push_back(e);
    wait_tab[n_push] = 0;
    rdata_tab[n_push] = rd;
    n_push++;
  endtask

  // Monitor: fetch stream, retire timestamps and completed data accesses.
  int          hold_cnt = 0;
  logic        stable;
  logic [68:0] first_req;
  always @(negedge clk) begin
    if (!rst_n) begin
      hold_cnt = 0;
    end else begin
      if (imem_req && imem_ready) begin
        n_fetch++;
        if (fq.size() > 0) chk("fetch_addr", imem_addr, fq.pop_front());
      end
      if (retire) begin
        if (ret_n < 64) ret_cyc[ret_n] = cyc;
        ret_n++;
      end
      if (dmem_req) begin
        if (hold_cnt == 0) begin
          first_req = {dmem_we, dmem_be, dmem_addr, dmem_wdata};
          stable = 1'b1;
        end else if (first_req !== {dmem_we, dmem_be, dmem_addr, dmem_wdata}) stable = 1'b0;
        hold_cnt++;
        if (dmem_ready) begin
          if (dq.size() == 0) begin
            n_chk++;
            $display("FAIL dmem_extra: unexpected access at %h", dmem_addr);
          end else begin
            dexp_t e;
            e = dq.pop_front();
            chk("dmem_addr", dmem_addr, e.addr);
            chk("dmem_we", {31'd0, dmem_we}, {31'd0, e.we});
            chk("dmem_be", {28'd0, dmem_be}, {28'd0, e.be});
            if (e.we) chk("dmem_wdata", dmem_wdata, e.wdata);
            chk("dmem_hold_cycles", hold_cnt, e.hold);
            chk("dmem_stable", {31'd0, stable}, 32'd1);
          end
          hold_cnt = 0;
        end
      end
    end
  end

  initial begin
    logic got;
    int   base, nf;
    for (int i = 0; i < 256; i++) rom[i] = 32'h0000_0013;
    for (int i = 0; i < 32; i++) begin wait_tab[i] = 0; rdata_tab[i] = 32'd0; end

    put(32'h100, enc_i(-5, 0, 3'b000, 1, c_IMM));              // addi x1,x0,-5
    put(32'h104, enc_i(1, 1, 3'b011, 2, c_IMM));               // sltiu x2,x1,1
    put(32'h108, enc_i(32'h401, 1, 3'b101, 3, c_IMM));         // srai x3,x1,1
    put(32'h10C, enc_s(0, 1, 0, 3'b010));
    put(32'h110, enc_s(4, 2, 0, 3'b010));
    put(32'h114, enc_s(8, 3, 0, 3'b010));
    put(32'h118, {20'h12345, 5'd5, 7'b0110111});               // lui x5,0x12345
    put(32'h11C, enc_i(32'h678, 5, 3'b000, 5, c_IMM));
    put(32'h120, enc_s(3, 5, 0, 3'b000));                      // sb x5,3(x0)
    put(32'h124, enc_i(2, 0, 3'b001, 6, c_LOAD));              // lh x6,2(x0)
    put(32'h128, enc_i(2, 0, 3'b101, 7, c_LOAD));              // lhu x7,2(x0)
    put(32'h12C, enc_s(12, 6, 0, 3'b010));
    put(32'h130, enc_s(16, 7, 0, 3'b010));
    put(32'h134, enc_i(-1, 0, 3'b000, 1, c_IMM));
    put(32'h138, enc_i(-1, 0, 3'b000, 2, c_IMM));
    put(32'h13C, enc_b(8, 2, 1, 3'b110));                      // bltu x1,x2 (not taken)
    put(32'h140, enc_b(8, 1, 0, 3'b100));                      // blt x0,x1 (not taken)
    put(32'h144, enc_b(8, 1, 0, 3'b101));                      // bge x0,x1 (taken)
    put(32'h148, enc_i(1, 0, 3'b000, 9, c_IMM));
    put(32'h14C, enc_i(32'h200, 0, 3'b000, 1, c_IMM));
    put(32'h150, enc_i(3, 1, 3'b000, 1, 7'b1100111));          // jalr x1,x1,3
    put(32'h200, enc_s(20, 1, 0, 3'b010));
    put(32'h204, enc_s(7, 5, 0, 3'b001));                      // sh x5,7(x0)
    put(32'h208, enc_i(1, 0, 3'b000, 8, c_LOAD));              // lb x8,1(x0)
    put(32'h20C, enc_s(24, 8, 0, 3'b010));
    put(32'h210, enc_i(5, 0, 3'b000, 0, c_IMM));               // addi x0,x0,5
    put(32'h214, enc_s(28, 0, 0, 3'b010));
    put(32'h218, enc_r(7'b0100000, 1, 5, 3'b000, 10));         // sub x10,x5,x1
    put(32'h21C, enc_s(36, 10, 0, 3'b010));
    put(32'h220, enc_r(7'b0000000, 8, 5, 3'b100, 11));         // xor x11,x5,x8
    put(32'h224, enc_s(40, 11, 0, 3'b010));
    put(32'h228, enc_r(7'b0100000, 1, 8, 3'b101, 12));         // sra x12,x8,x1
    put(32'h22C, enc_s(44, 12, 0, 3'b010));
    put(32'h230, enc_r(7'b0000000, 8, 5, 3'b111, 13));         // and x13,x5,x8
    put(32'h234, enc_s(48, 13, 0, 3'b010));
    put(32'h238, enc_i(0, 0, 3'b010, 4, c_LOAD));              // lw x4,0(x0), interrupted

    exp_st(32'd0,  4'b1111, 32'hFFFF_FFFB, 0);
    exp_st(32'd4,  4'b1111, 32'h0000_0000, 0);
    exp_st(32'd8,  4'b1111, 32'hFFFF_FFFD, 0);
    exp_st(32'd0,  4'b1000, 32'h7800_0000, 3);
    exp_ld(32'd0,  32'h80FF_0000);
    exp_ld(32'd0,  32'h80FF_0000);
    exp_st(32'd12, 4'b1111, 32'hFFFF_80FF, 0);
    exp_st(32'd16, 4'b1111, 32'h0000_80FF, 0);
    exp_st(32'd20, 4'b1111, 32'h0000_0154, 0);
    exp_st(32'd4,  4'b1000, 32'h7800_0000, 0);
    exp_ld(32'd0,  32'h0000_8000);
    exp_st(32'd24, 4'b1111, 32'hFFFF_FF80, 0);
    exp_st(32'd28, 4'b1111, 32'h0000_0000, 0);
    exp_st(32'd36, 4'b1111, 32'h1234_5524, 0);
    exp_st(32'd40, 4'b1111, 32'hEDCB_A9F8, 0);
    exp_st(32'd44, 4'b1111, 32'hFFFF_FFFF, 0);
    exp_st(32'd48, 4'b1111, 32'h1234_5600, 0);
    wait_tab[n_push] = 1000;

    for (int a = 32'h100; a <= 32'h144; a += 4) fq.push_back(32'(a));
    fq.push_back(32'h14C);
    fq.push_back(32'h150);
    for (int a = 32'h202; a <= 32'h23A; a += 4) fq.push_back(32'(a));

    repeat (3) @(posedge clk);
    #1;
    chk("rst_imem_req", {31'd0, imem_req}, 32'd0);
    chk("rst_imem_addr", imem_addr, 32'd0);
    chk("rst_dmem_req", {31'd0, dmem_req}, 32'd0);
    chk("rst_retire", {31'd0, retire}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("first_imem_req", {31'd0, imem_req}, 32'd1);
    chk("first_imem_addr", imem_addr, 32'h100);

    got = 1'b0;
    for (int i = 0; i < 3000 && !got; i++) begin
      @(posedge clk);
      #1;
      if (acc_n == 17 && dmem_req) got = 1'b1;
    end
    if (!got) fail_now("reach_lw");
    @(posedge clk);
    #3;
    chk("lw_req", {31'd0, dmem_req}, 32'd1);
    chk("lw_we", {31'd0, dmem_we}, 32'd0);
    chk("lw_be", {28'd0, dmem_be}, 32'd0);
    chk("lw_addr", dmem_addr, 32'd0);
    rst_n = 1'b0;
    #1;
    chk("midreset_dmem_req", {31'd0, dmem_req}, 32'd0);
    chk("midreset_imem_req", {31'd0, imem_req}, 32'd0);
    chk("midreset_retire", {31'd0, retire}, 32'd0);
    chk("retire_count", ret_n, 34);
    chk("retire_gap_alu1", ret_cyc[1] - ret_cyc[0], 2);
    chk("retire_gap_alu2", ret_cyc[2] - ret_cyc[1], 2);
    chk("retire_gap_store", ret_cyc[3] - ret_cyc[2], 3);
    chk("retire_gap_sb_wait3", ret_cyc[8] - ret_cyc[7], 6);

    put(32'h100, enc_s(32, 5, 0, 3'b010));                     // sw x5,32(x0): x5 cleared
    put(32'h104, 32'hFFFF_FFFF);
    put(32'h108, {20'd0, 5'd0, 7'b1101111});                   // jal x0,0
    exp_st(32'd32, 4'b1111, 32'h0000_0000, 0);
    fq.push_back(32'h100);
    fq.push_back(32'h104);
`ifndef RV_ILLEGAL_HALT_EN
    fq.push_back(32'h108);
`endif
    base = ret_n;
    #20;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    chk("fetch_queue_drained", fq.size(), 0);
    chk("dmem_queue_drained", dq.size(), 0);
`ifdef RV_ILLEGAL_HALT_EN
    chk("halted", {31'd0, halted}, 32'd1);
    chk("halt_imem_req", {31'd0, imem_req}, 32'd0);
    chk("halt_retires", ret_n - base, 1);
    nf = n_fetch;
    repeat (20) @(posedge clk);
    #1;
    chk("halt_no_fetch", n_fetch, nf);
    chk("halt_still_halted", {31'd0, halted}, 32'd1);
`else
    chk("halted_tied_low", {31'd0, halted}, 32'd0);
    chk("illegal_nop_retires", {31'd0, (ret_n - base) >= 3}, 32'd1);
    nf = n_fetch;
    repeat (20) @(posedge clk);
    #1;
    chk("loop_keeps_fetching", {31'd0, n_fetch > nf}, 32'd1);
`endif
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/rv32i_mc_core.md
Name: rv32i_mc_core

Overview:
Multi-cycle RV32I core, successor to the single-cycle CPU. Adds:
- full RV32I integer ISA
- valid/ready handshakes on the instruction and data buses, so memories may stall
- a parametrised register file size (RV32E-style 16 registers)
- a configurable reset vector

It sits between the instruction ROM/bus and the data RAM/bus of the SoC top.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
NUM_REGS, 32, architectural register count; legal values 16 or 32.

Ports:
clk  in  1  core clock; all state updates on rising edge.
rst_n  in  1  asynchronous, active-low reset.
imem_req  out  1  instruction fetch request.
imem_addr  out  32  fetch address (= pc).
imem_ready  in  1  fetch complete; imem_rdata valid this cycle.
imem_rdata  in  32  instruction word.
dmem_req  out  1  data access request.
dmem_we  out  1  1 = store, 0 = load.
dmem_be  out  4  byte enables (stores; all 0 for loads).
dmem_addr  out  32  word-aligned data address ({ea[31:2],2'b00}).
dmem_wdata  out  32  store data, shifted to byte lane.
dmem_ready  in  1  access complete; dmem_rdata valid this cycle for loads.
dmem_rdata  in  32  load data word.
retire  out  1  one-cycle pulse when an instruction commits.
halted  out  1  core stopped (only with optional feature).

Behaviour:
- Reset (async, rst_n=0):
  - pc=RESET_PC, state=FETCH, all registers 0.
  - All outputs 0 immediately, including mid-request; no handshake completes.
- FSM states FETCH, EXEC, MEM (HALT only with feature).
- FETCH:
  - imem_req=1, imem_addr=pc; hold until imem_ready.
  - On imem_ready: latch imem_rdata into IR, go to EXEC.
  - imem_req may be asserted in the same cycle as imem_ready (zero-wait memory).
- EXEC (single cycle):
  - Decode IR, read rs1/rs2, compute.
  - Non-memory ops write rd, update pc, pulse retire, go to FETCH.
  - LOAD/STORE go to MEM; pc and rd are untouched here.
- MEM:
  - dmem_req=1 with stable addr/we/be/wdata until dmem_ready.
  - On dmem_ready: a load writes rd from dmem_rdata of that cycle; pc += 4; retire=1; go to FETCH.
- Supported instructions:
  - LUI, AUIPC, JAL, JALR (target bit0 cleared).
  - BEQ/BNE/BLT/BGE/BLTU/BGEU.
  - LB/LH/LW/LBU/LHU, SB/SH/SW.
  - All OP-IMM incl. SLTI/SLTIU/XORI/ORI/ANDI/SLLI/SRLI/SRAI.
  - All OP (ADD/SUB/SLL/SLT/SLTU/XOR/SRL/SRA/OR/AND).
- Immediates are sign-extended to 32 bits; shift amount is the low 5 bits; arithmetic wraps mod 2^32.
- x0 reads 0 always; writes to x0 are discarded.
- NUM_REGS=16: register index bit4 set reads 0, writes discarded.
- Stores:
  - be = 0001 (SB), 0011 (SH) or 1111 (SW), shifted left by ea[1:0].
  - wdata = rs2 << (8*ea[1:0]).
  - Bits shifted past lane 3 are dropped (misaligned accesses are truncated, never split).
- Loads: data = dmem_rdata >> (8*ea[1:0]), then sign- or zero-extend per funct3.
- Minimum latency with zero-wait memories:
  - 2 cycles for non-memory instructions.
  - 3 cycles for loads/stores.
  - Each wait cycle adds 1.
- Branch taken: pc = pc + immB. Not taken: pc + 4. JAL/JALR write pc+4 to rd before the pc update (rd == rs1 on JALR uses the old rs1).
- Unknown opcode/funct: treated as NOP (pc += 4, retire=1) unless the feature below is enabled.
- halted=0 always without the feature.

Optional Feature:
Macro RV_ILLEGAL_HALT_EN.
- Defined: an unknown opcode, or an unsupported funct3/funct7, in EXEC enters HALT.
  - halted=1, no retire, no bus requests, pc frozen at the offending instruction.
  - Exits only via rst_n.
- Undefined: the HALT state is not built; illegal instructions retire as NOP and halted ties to 0.

Test Plan:
- Reset with RESET_PC=32'h100, zero-wait imem → first cycle after rst_n release: imem_req=1, imem_addr=32'h100.
- addi x1,x0,-5; sltiu x2,x1,1; srai x3,x1,1 → x1=32'hFFFF_FFFB, x2=0, x3=32'hFFFF_FFFD; 3 retire pulses, 2 cycles apart.
- x5=32'h1234_5678, sb x5,3(x0) with dmem_ready delayed 3 cycles → dmem_addr=0, be=4'b1000, wdata=32'h7800_0000 held stable 4 cycles; one retire.
- dmem_rdata=32'h80FF_0000, lh x6,2(x0) → x6=32'hFFFF_80FF; lhu → 32'h0000_80FF.
- x1=x2=-1: bltu x1,x2,+8 not taken (pc+4); blt x0,x1,+8 not taken; bge x0,x1,+8 taken (pc+8). jalr x1,x1,3 with x1=32'h200 → pc=32'h202, x1=old pc+4.
- rst_n dropped mid-MEM while dmem_req=1 → dmem_req=0 the same cycle, registers cleared. With RV_ILLEGAL_HALT_EN, word 32'hFFFF_FFFF → halted=1, no further imem_req.
